// File: rtl/usb_buffer_pkg.sv
// Shared definitions for the USB endpoint packet FIFO: default sizes,
// derived-width helpers and the default-depth pointer type.
package usb_buffer_pkg;

   localparam int unsigned DATA_W_DEFAULT = 8;
   localparam int unsigned DEPTH_DEFAULT  = 64;

   // Width needed to count 0..depth committed entries.
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Address bits plus one wrap bit, so full and empty are distinguishable.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   typedef logic [ptr_width(DEPTH_DEFAULT)-1:0] ptr_t;

endpackage

// File: rtl/usb_packet_fifo_ram.sv
// Storage array for the packet FIFO: DEPTH x DATA_W, one synchronous write
// port and one asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module usb_packet_fifo_ram
   import usb_buffer_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned DEPTH  = DEPTH_DEFAULT,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/usb_packet_fifo.sv
// Circular FIFO between the AHB slave and the USB TX/RX packet engines.
// RX bytes are staged between cmt_ptr and wr_ptr and become readable only
// on RX_Commit; RX_Abort rolls wr_ptr back to cmt_ptr.
// Optional error flags: define USB_PACKET_FIFO_ERR_EN to build them,
// otherwise Overflow_Err/Underflow_Err are tied low.
// Ports:
//   clk, rst                        : clock, async active-high reset
//   Store_TX_Data/TX_Data           : AHB push (committed immediately)
//   Store_RX_Packet_Data/RX_Packet_Data : RX engine push (staged)
//   RX_Commit, RX_Abort             : publish / discard staged RX bytes
//   Get_TX_Packet_Data              : TX engine pop -> TX_Packet_Data
//   Get_RX_Data                     : AHB pop -> RX_Data
//   flush, clear                    : empty FIFO (clear also zeroes outputs/errors)
//   Buffer_Occupancy/Full/Empty     : status flags
//   Overflow_Err, Underflow_Err     : sticky error flags
module usb_packet_fifo
   import usb_buffer_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned DEPTH  = DEPTH_DEFAULT,
   localparam int unsigned OCC_W = occ_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Store_TX_Data,
   input  logic [DATA_W-1:0] TX_Data,
   input  logic              Store_RX_Packet_Data,
   input  logic [DATA_W-1:0] RX_Packet_Data,
   input  logic              RX_Commit,
   input  logic              RX_Abort,
   input  logic              Get_TX_Packet_Data,
   input  logic              Get_RX_Data,
   input  logic              flush,
   input  logic              clear,
   output logic [OCC_W-1:0]  Buffer_Occupancy,
   output logic              Buffer_Full,
   output logic              Buffer_Empty,
   output logic [DATA_W-1:0] TX_Packet_Data,
   output logic [DATA_W-1:0] RX_Data,
   output logic              Overflow_Err,
   output logic              Underflow_Err
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = ptr_width(DEPTH);

   typedef logic [PTR_W-1:0] fifo_ptr_t;

   fifo_ptr_t wr_ptr, cmt_ptr, rd_ptr;
   fifo_ptr_t wr_ptr_n, cmt_ptr_n, rd_ptr_n;
   fifo_ptr_t occ, total;

   logic              drain;
   logic              rx_push, tx_push, push;
   logic              pop_tx, pop_rx;
   logic [DATA_W-1:0] wdata, rdata;

   // Status derived purely from pointer registers.
   assign occ              = cmt_ptr - rd_ptr;
   assign total            = wr_ptr - rd_ptr;
   assign Buffer_Occupancy = OCC_W'(occ);
   assign Buffer_Full      = (total == PTR_W'(DEPTH));
   assign Buffer_Empty     = (occ == '0);

   // Arbitration: clear/flush suppress traffic, RX push beats TX push, TX pop beats RX pop.
   assign drain   = clear | flush;
   assign rx_push = ~drain & ~Buffer_Full & Store_RX_Packet_Data;
   assign tx_push = ~drain & ~Buffer_Full & Store_TX_Data & ~Store_RX_Packet_Data;
   assign push    = rx_push | tx_push;
   assign wdata   = rx_push ? RX_Packet_Data : TX_Data;
   assign pop_tx  = ~drain & ~Buffer_Empty & Get_TX_Packet_Data;
   assign pop_rx  = ~drain & ~Buffer_Empty & Get_RX_Data & ~Get_TX_Packet_Data;

   usb_packet_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wdata),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata)
   );

   // Next pointers; abort/commit act on the post-push values.
   always_comb begin
      wr_ptr_n  = wr_ptr;
      cmt_ptr_n = cmt_ptr;
      rd_ptr_n  = rd_ptr;
      if (drain) begin
         wr_ptr_n  = '0;
         cmt_ptr_n = '0;
         rd_ptr_n  = '0;
      end else begin
         if (push)           wr_ptr_n  = wr_ptr + PTR_W'(1);
         if (tx_push)        cmt_ptr_n = cmt_ptr + PTR_W'(1);
         if (pop_tx | pop_rx) rd_ptr_n = rd_ptr + PTR_W'(1);
         if (RX_Abort)       wr_ptr_n  = cmt_ptr_n;
         else if (RX_Commit) cmt_ptr_n = wr_ptr_n;
      end
   end

   // Pointer and output data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr         <= '0;
         cmt_ptr        <= '0;
         rd_ptr         <= '0;
         TX_Packet_Data <= '0;
         RX_Data        <= '0;
      end else begin
         wr_ptr  <= wr_ptr_n;
         cmt_ptr <= cmt_ptr_n;
         rd_ptr  <= rd_ptr_n;
         if (clear) begin
            TX_Packet_Data <= '0;
            RX_Data        <= '0;
         end else begin
            if (pop_tx) TX_Packet_Data <= rdata;
            if (pop_rx) RX_Data        <= rdata;
         end
      end
   end

`ifdef USB_PACKET_FIFO_ERR_EN
   logic ovf_ev, unf_ev;

   // Dropped push: FIFO full or TX byte lost to a simultaneous RX push.
   assign ovf_ev = ~drain & (((Store_RX_Packet_Data | Store_TX_Data) & Buffer_Full) |
                             (Store_RX_Packet_Data & Store_TX_Data));
   assign unf_ev = ~drain & (Get_TX_Packet_Data | Get_RX_Data) & Buffer_Empty;

   // Sticky error flags; only clear or reset release them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Overflow_Err  <= 1'b0;
         Underflow_Err <= 1'b0;
      end else if (clear) begin
         Overflow_Err  <= 1'b0;
         Underflow_Err <= 1'b0;
      end else begin
         if (ovf_ev) Overflow_Err  <= 1'b1;
         if (unf_ev) Underflow_Err <= 1'b1;
      end
   end
`else
   assign Overflow_Err  = 1'b0;
   assign Underflow_Err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_packet_fifo.sv
// Directed self-checking bench for usb_packet_fifo (default DATA_W=8, DEPTH=64).
module tb_usb_packet_fifo;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned OCC_W  = 7;
`ifdef USB_PACKET_FIFO_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              Store_TX_Data, Store_RX_Packet_Data;
   logic [DATA_W-1:0] TX_Data, RX_Packet_Data;
   logic              RX_Commit, RX_Abort;
   logic              Get_TX_Packet_Data, Get_RX_Data;
   logic              flush, clear;
   logic [OCC_W-1:0]  Buffer_Occupancy;
   logic              Buffer_Full, Buffer_Empty;
   logic [DATA_W-1:0] TX_Packet_Data, RX_Data;
   logic              Overflow_Err, Underflow_Err;

   int unsigned errors = 0;
   int unsigned checks = 0;

   usb_packet_fifo dut (
      .clk                  (clk),
      .rst                  (rst),
      .Store_TX_Data        (Store_TX_Data),
      .TX_Data              (TX_Data),
      .Store_RX_Packet_Data (Store_RX_Packet_Data),
      .RX_Packet_Data       (RX_Packet_Data),
      .RX_Commit            (RX_Commit),
      .RX_Abort             (RX_Abort),
      .Get_TX_Packet_Data   (Get_TX_Packet_Data),
      .Get_RX_Data          (Get_RX_Data),
      .flush                (flush),
      .clear                (clear),
      .Buffer_Occupancy     (Buffer_Occupancy),
      .Buffer_Full          (Buffer_Full),
      .Buffer_Empty         (Buffer_Empty),
      .TX_Packet_Data       (TX_Packet_Data),
      .RX_Data              (RX_Data),
      .Overflow_Err         (Overflow_Err),
      .Underflow_Err        (Underflow_Err)
   );

   always #5 clk = ~clk;

   // One active edge, then settle 1 time unit before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      Store_TX_Data = 1'b0; Store_RX_Packet_Data = 1'b0;
      RX_Commit = 1'b0; RX_Abort = 1'b0;
      Get_TX_Packet_Data = 1'b0; Get_RX_Data = 1'b0;
      flush = 1'b0; clear = 1'b0;
   endtask

   task automatic push_tx(input logic [7:0] d);
      Store_TX_Data = 1'b1; TX_Data = d; tick(); Store_TX_Data = 1'b0;
   endtask

   task automatic push_rx(input logic [7:0] d);
      Store_RX_Packet_Data = 1'b1; RX_Packet_Data = d; tick(); Store_RX_Packet_Data = 1'b0;
   endtask

   task automatic pulse_commit();
      RX_Commit = 1'b1; tick(); RX_Commit = 1'b0;
   endtask

   task automatic pop_tx_chk(input string tag, input logic [7:0] exp);
      Get_TX_Packet_Data = 1'b1; tick(); Get_TX_Packet_Data = 1'b0;
      check(tag, 32'(TX_Packet_Data), 32'(exp));
   endtask

   task automatic pop_rx_chk(input string tag, input logic [7:0] exp);
      Get_RX_Data = 1'b1; tick(); Get_RX_Data = 1'b0;
      check(tag, 32'(RX_Data), 32'(exp));
   endtask

   initial begin
      idle();
      TX_Data = '0; RX_Packet_Data = '0;
      rst = 1'b1;
      tick(); tick();
      check("rst_occ",   32'(Buffer_Occupancy), 32'd0);
      check("rst_empty", 32'(Buffer_Empty), 32'd1);
      check("rst_full",  32'(Buffer_Full), 32'd0);
      check("rst_txd",   32'(TX_Packet_Data), 32'd0);
      check("rst_rxd",   32'(RX_Data), 32'd0);
      check("rst_ovf",   32'(Overflow_Err), 32'd0);
      check("rst_unf",   32'(Underflow_Err), 32'd0);
      rst = 1'b0;
      tick();

      // 1: TX path
      push_tx(8'hF1);
      push_tx(8'h33);
      check("t1_occ2",  32'(Buffer_Occupancy), 32'd2);
      check("t1_empty0", 32'(Buffer_Empty), 32'd0);
      pop_tx_chk("t1_pop0", 8'hF1);
      pop_tx_chk("t1_pop1", 8'h33);
      check("t1_empty", 32'(Buffer_Empty), 32'd1);
      check("t1_rxhold", 32'(RX_Data), 32'd0);

      // 2: RX staging
      push_rx(8'hFF);
      push_rx(8'hAA);
      check("t2_staged_occ",   32'(Buffer_Occupancy), 32'd0);
      check("t2_staged_empty", 32'(Buffer_Empty), 32'd1);
      pulse_commit();
      check("t2_commit_occ", 32'(Buffer_Occupancy), 32'd2);
      pop_rx_chk("t2_pop0", 8'hFF);
      check("t2_txhold", 32'(TX_Packet_Data), 32'h33);
      pop_rx_chk("t2_pop1", 8'hAA);

      // 3: RX abort; commit in the same cycle as a push includes that byte
      Store_RX_Packet_Data = 1'b1; RX_Packet_Data = 8'h11; RX_Commit = 1'b1;
      tick(); idle();
      check("t3_commit_occ", 32'(Buffer_Occupancy), 32'd1);
      push_rx(8'h22);
      push_rx(8'h33);
      RX_Abort = 1'b1; tick(); RX_Abort = 1'b0;
      check("t3_abort_occ", 32'(Buffer_Occupancy), 32'd1);
      push_rx(8'h44);
      pulse_commit();
      check("t3_occ2", 32'(Buffer_Occupancy), 32'd2);
      pop_rx_chk("t3_pop0", 8'h11);
      pop_rx_chk("t3_pop1", 8'h44);

      // Abort beats commit: staged byte dropped
      push_rx(8'h55);
      RX_Abort = 1'b1; RX_Commit = 1'b1; tick(); idle();
      check("t3_abort_over_commit", 32'(Buffer_Occupancy), 32'd0);
      pulse_commit();
      check("t3_nothing_staged", 32'(Buffer_Occupancy), 32'd0);

      // 4: Full and wrap (pointers start at 6, so the array wraps)
      for (int i = 0; i < 64; i++) push_tx(8'(i));
      check("t4_full",    32'(Buffer_Full), 32'd1);
      check("t4_occ64",   32'(Buffer_Occupancy), 32'd64);
      push_tx(8'hEE);
      check("t4_drop_occ", 32'(Buffer_Occupancy), 32'd64);
      check("t4_ovf",      32'(Overflow_Err), 32'(ERR_EXP));
      // Push while full with a same-cycle pop: push dropped, pop happens
      Store_TX_Data = 1'b1; TX_Data = 8'hEF; Get_TX_Packet_Data = 1'b1;
      tick(); idle();
      check("t4_fullpop_data", 32'(TX_Packet_Data), 32'h00);
      check("t4_fullpop_occ",  32'(Buffer_Occupancy), 32'd63);
      for (int i = 1; i < 10; i++) pop_tx_chk("t4_pop_head", 8'(i));
      for (int i = 0; i < 10; i++) push_tx(8'(8'h80 + i));
      check("t4_refill_occ", 32'(Buffer_Occupancy), 32'd64);
      for (int i = 10; i < 64; i++) pop_tx_chk("t4_pop_old", 8'(i));
      for (int i = 0; i < 10; i++) pop_tx_chk("t4_pop_new", 8'(8'h80 + i));
      check("t4_empty", 32'(Buffer_Empty), 32'd1);
      Get_TX_Packet_Data = 1'b1; tick(); Get_TX_Packet_Data = 1'b0;
      check("t4_underflow_hold", 32'(TX_Packet_Data), 32'h89);
      check("t4_unf", 32'(Underflow_Err), 32'(ERR_EXP));

      // 5: flush vs clear
      push_tx(8'h99);
      pop_rx_chk("t5_rx99", 8'h99);
      push_tx(8'h01);
      push_tx(8'h02);
      Store_TX_Data = 1'b1; TX_Data = 8'h03; flush = 1'b1; tick(); idle();
      check("t5_flush_occ", 32'(Buffer_Occupancy), 32'd0);
      check("t5_flush_rx",  32'(RX_Data), 32'h99);
      check("t5_flush_ovf", 32'(Overflow_Err), 32'(ERR_EXP));
      clear = 1'b1; tick(); clear = 1'b0;
      check("t5_clear_rx",  32'(RX_Data), 32'd0);
      check("t5_clear_tx",  32'(TX_Packet_Data), 32'd0);
      check("t5_clear_ovf", 32'(Overflow_Err), 32'd0);
      check("t5_clear_unf", 32'(Underflow_Err), 32'd0);

      // 6: simultaneous RX/TX push keeps only the RX byte
      Store_RX_Packet_Data = 1'b1; RX_Packet_Data = 8'h5A;
      Store_TX_Data = 1'b1; TX_Data = 8'hA5;
      tick(); idle();
      check("t6_collide_occ", 32'(Buffer_Occupancy), 32'd0);
      pulse_commit();
      check("t6_commit_occ", 32'(Buffer_Occupancy), 32'd1);
      pop_rx_chk("t6_rx_only", 8'h5A);
      check("t6_empty", 32'(Buffer_Empty), 32'd1);
      check("t6_ovf",   32'(Overflow_Err), 32'(ERR_EXP));
      push_tx(8'h01);
      push_tx(8'h02);
      push_tx(8'h03);
      Store_TX_Data = 1'b1; TX_Data = 8'h04; Get_TX_Packet_Data = 1'b1;
      tick(); idle();
      check("t6_pushpop_occ",  32'(Buffer_Occupancy), 32'd3);
      check("t6_pushpop_data", 32'(TX_Packet_Data), 32'h01);
      // TX pop beats RX pop
      Get_TX_Packet_Data = 1'b1; Get_RX_Data = 1'b1; tick(); idle();
      check("t6_popprio_tx", 32'(TX_Packet_Data), 32'h02);
      check("t6_popprio_rx", 32'(RX_Data), 32'h5A);

      // Async reset mid-packet
      push_rx(8'h77);
      #2 rst = 1'b1;
      #1;
      check("rst_async_occ", 32'(Buffer_Occupancy), 32'd0);
      check("rst_async_tx",  32'(TX_Packet_Data), 32'd0);
      check("rst_async_rx",  32'(RX_Data), 32'd0);
      tick();
      rst = 1'b0;
      pulse_commit();
      check("rst_staged_lost", 32'(Buffer_Occupancy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
